// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: clocked instruction decoder and sequencer.
// It decodes the opcode and stretches ld/str over MEM_LAT wait cycles.
// It holds the Z/N compare flags used by conditional jumps.
// It runs the start/halt/done handshake with the top level.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | out of reset, all outputs low, waiting for start
// S_EXEC   | executing the presented instruction (first cycle of ld/str)
// S_MEMWAIT| extra ld/str cycles, wait counter counts down to 0
// S_HALT   | program halted, done high until the next start
module ctrl_sequencer #(
  parameter int OPWIDTH   = 3,
  parameter int MCODEBITS = 4,
  parameter int MEM_LAT   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 alu_zero,
  input  logic                 alu_neg,
  output logic                 PCEn,
  output logic                 UncondJump,
  output logic                 BranchTaken,
  output logic                 RdMem,
  output logic                 WrMem,
  output logic                 IType,
  output logic                 RegWrite,
  output logic                 Movf,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 done,
  output logic                 illegal
);

  localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  localparam logic [CW-1:0] WAIT_INIT = CW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_EXEC    = 2'd1;
  localparam logic [1:0] S_MEMWAIT = 2'd2;
  localparam logic [1:0] S_HALT    = 2'd3;

  localparam logic [3:0] OP_JMP  = 4'b0000;
  localparam logic [3:0] OP_BEQ  = 4'b0001;
  localparam logic [3:0] OP_BNE  = 4'b0010;
  localparam logic [3:0] OP_BLT  = 4'b0011;
  localparam logic [3:0] OP_BGE  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_LD   = 4'b1000;
  localparam logic [3:0] OP_NOP  = 4'b1001;
  localparam logic [3:0] OP_MOVF = 4'b1010;
  localparam logic [3:0] OP_SUB  = 4'b1011;
  localparam logic [3:0] OP_CMP  = 4'b1100;
  localparam logic [3:0] OP_LSL  = 4'b1101;
  localparam logic [3:0] OP_MOVI = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          z_q, z_d, n_q, n_d;
  logic          illegal_q, illegal_d;
  logic          upper_bad;
  logic [3:0]    opcode;
  logic          is_mem;
  logic          mem_last;

  // Any nonzero bit above the 4-bit opcode field makes the instruction illegal.
  if (MCODEBITS > 4) begin : g_upper
    assign upper_bad = |instr[MCODEBITS-1:4];
  end else begin : g_no_upper
    assign upper_bad = 1'b0;
  end

  assign opcode = upper_bad ? OP_NOP : instr[3:0];
  assign is_mem = (opcode == OP_LD) || (opcode == OP_STR);
  // Last cycle of a memory access: the wait counter has expired, or there is no wait at all.
  assign mem_last = (state_q == S_MEMWAIT) ? (cnt_q == '0) : (MEM_LAT == 0);

  // Next-state, wait counter, flag and sticky-illegal logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    z_d       = z_q;
    n_d       = n_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_EXEC;
      S_EXEC: begin
        if (upper_bad) illegal_d = 1'b1;
        if (opcode == OP_CMP) begin
          z_d = alu_zero;
          n_d = alu_neg;
        end
        if (is_mem && (MEM_LAT > 0)) begin
          state_d = S_MEMWAIT;
          cnt_d   = WAIT_INIT;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end
      end
      S_MEMWAIT: begin
        if (cnt_q == '0) state_d = S_EXEC;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_HALT: if (start) state_d = S_EXEC;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset returns to IDLE from anywhere, including MEMWAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      z_q       <= z_d;
      n_q       <= n_d;
      illegal_q <= illegal_d;
    end
  end

  // Output decode from state, opcode and the registered flags
  always_comb begin
    PCEn        = 1'b0;
    UncondJump  = 1'b0;
    BranchTaken = 1'b0;
    RdMem       = 1'b0;
    WrMem       = 1'b0;
    IType       = 1'b0;
    RegWrite    = 1'b0;
    Movf        = 1'b0;
    ALUOp       = '0;
    done        = (state_q == S_HALT);
    if ((state_q == S_EXEC) || (state_q == S_MEMWAIT)) begin
      PCEn = 1'b1;
      case (opcode)
        OP_JMP: begin
          UncondJump  = 1'b1;
          BranchTaken = 1'b1;
        end
        OP_BEQ: BranchTaken = z_q;
        OP_BNE: BranchTaken = ~z_q;
        OP_BLT: BranchTaken = n_q;
        OP_BGE: BranchTaken = ~n_q;
        OP_ADD: RegWrite = 1'b1;
        OP_XOR: begin
          RegWrite = 1'b1;
          ALUOp    = OPWIDTH'(3'b011);
        end
        OP_STR: begin
          WrMem = 1'b1;
          PCEn  = mem_last;
        end
        OP_LD: begin
          RdMem    = 1'b1;
          PCEn     = mem_last;
          RegWrite = mem_last;
        end
        OP_MOVF: begin
          Movf     = 1'b1;
          RegWrite = 1'b1;
        end
        OP_SUB: begin
          RegWrite = 1'b1;
          ALUOp    = OPWIDTH'(3'b110);
        end
        OP_CMP: ALUOp = OPWIDTH'(3'b111);
        OP_LSL: begin
          IType    = 1'b1;
          RegWrite = 1'b1;
          ALUOp    = OPWIDTH'(3'b001);
        end
        OP_MOVI: begin
          IType    = 1'b1;
          RegWrite = 1'b1;
        end
        OP_HALT: PCEn = 1'b0;
        default: ;
      endcase
    end
  end

  assign illegal = illegal_q;

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised, clocked successor to the combinational control decoder. It decodes the instruction opcode and sequences multi-cycle memory accesses with a configurable wait count. It keeps the compare flags that drive conditional jumps and runs a start/halt/done handshake with the top level. It sits between instruction memory and the datapath (PC, register file, ALU, data memory) and gates PC advance.

## Interface
Parameters:
- OPWIDTH, 3, ALUOp width (up to 8 ALU operations)
- MCODEBITS, 4, instruction field width presented on instr; must be ≥ 4
- MEM_LAT, 2, extra wait cycles per ld/str (0–15)

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins execution from IDLE or HALT
- instr  input  MCODEBITS  opcode field of current instruction
- alu_zero  input  1  ALU result == 0, sampled on cmp
- alu_neg  input  1  ALU result sign bit, sampled on cmp
- PCEn  output  1  PC may update this cycle
- UncondJump  output  1  unconditional jump
- BranchTaken  output  1  PC loads jump target (uncond, or cond and condition true)
- RdMem, WrMem  output  1 each  data-memory read / write enable
- IType  output  1  ALU second operand is the immediate
- RegWrite  output  1  register-file write enable
- Movf  output  1  movf instruction
- ALUOp  output  OPWIDTH  ALU operation
- done  output  1  program halted; held until next start
- illegal  output  1  sticky: opcode with nonzero upper bits seen

## Operation
- Opcode = instr[3:0]. If MCODEBITS > 4 and instr[MCODEBITS-1:4] ≠ 0, the instruction executes as NOP and illegal is set.
- Opcode map:
  - 0000 jmp: UncondJump, BranchTaken
  - 0001 beq (Z), 0010 bne (!Z), 0011 blt (N), 0100 bge (!N): BranchTaken only if the condition holds
  - 0101 add: ALUOp 000
  - 0110 xor: ALUOp 011
  - 0111 str: WrMem
  - 1000 ld: RdMem, RegWrite on final cycle
  - 1001 nop
  - 1010 movf: Movf
  - 1011 sub: ALUOp 110
  - 1100 cmp: ALUOp 111, updates flags
  - 1101 lsl: IType, ALUOp 001
  - 1110 movi: IType
  - 1111 halt
- RegWrite = 1 only for add, xor, sub, lsl, movi, movf, and ld (final cycle). It is 0 for jumps, str, cmp, nop, halt.
- ALUOp = 000 for any opcode not listed with an ALUOp.
- Flags Z/N are registered. They load alu_zero/alu_neg on the EXEC edge of cmp only and are unchanged otherwise.
- FSM states:
  - IDLE: all outputs 0. start → EXEC.
  - EXEC:
    - ld/str with MEM_LAT > 0 → MEMWAIT, wait counter = MEM_LAT−1.
    - halt → HALT.
    - Otherwise stay in EXEC.
  - MEMWAIT: counter decrements each cycle. At 0 → EXEC.
  - HALT: done = 1, other outputs 0. start → EXEC, done clears.
- Outputs are combinational from state, decoded opcode and flags.
- Counter width is clog2(MEM_LAT+1), minimum 1 bit.
- start in EXEC or MEMWAIT is ignored.

## Timing
- Reset (async, any state including MEMWAIT) → state IDLE, Z=N=0, counter 0, illegal 0. All outputs 0 immediately, without waiting for a clock edge.
- Single-cycle instructions: PCEn = 1 in their EXEC cycle (1 CPI). halt has PCEn = 0.
- ld/str occupy 1 + MEM_LAT cycles:
  - RdMem/WrMem are held high on every cycle.
  - PCEn = 0 until the final cycle, then PCEn = 1.
  - For ld, RegWrite = 1 on the final cycle only.
  - With MEM_LAT = 0, a ld/str completes in its single EXEC cycle.
- Conditional jump immediately after cmp sees the flags written at the cmp edge (zero bubble).
- The cmp cycle itself uses the old flags. A cmp does not affect its own outputs.
- instr must be stable throughout MEMWAIT; it is not re-sampled.
- First EXEC cycle follows the start edge, so latency start → first PCEn is 1 cycle.

## Test plan
- Reset then start, instr=0101 → PCEn=1, RegWrite=1, ALUOp=000, IType=0 on the cycle after start. Assert rst_n=0 mid-cycle → all outputs 0 at once.
- MEM_LAT=2, ld (1000) → RdMem=1 for 3 cycles; PCEn=0,0,1; RegWrite=0,0,1. str (0111) → WrMem=1 for 3 cycles, RegWrite=0 throughout.
- cmp (1100) with alu_zero=1, next beq (0001) → BranchTaken=1. Then cmp with alu_zero=0, alu_neg=1, next bne → BranchTaken=1, bge → BranchTaken=0, blt → BranchTaken=1.
- jmp (0000) → UncondJump=1, BranchTaken=1, RegWrite=0. halt (1111) → next cycle done=1, PCEn=0. start → done=0, execution resumes.
- MCODEBITS=6, instr=6'b010101 → behaves as NOP (RegWrite=0, PCEn=1); illegal=1 and stays 1 until reset.
- Reset asserted during MEMWAIT of a ld with MEM_LAT=15 → IDLE, no RegWrite pulse. Subsequent start executes normally.
